// File: rtl/pipe_drain_if.sv
// Handshake bundle between the pipeline front end and the drain controller.
// The pipeline (master) raises halt/stall/flush; the controller (slave)
// answers with fetch gating and drain progress.
interface pipe_drain_if;
  logic       halt_req;
  logic       stall;
  logic       flush;
  logic       fetch_en;
  logic       drain;
  logic       last;
  logic       done;
  logic [3:0] drain_cnt;

  modport master (
    output halt_req, stall, flush,
    input  fetch_en, drain, last, done, drain_cnt
  );

  modport slave (
    input  halt_req, stall, flush,
    output fetch_en, drain, last, done, drain_cnt
  );
endinterface

// File: rtl/pipe_drain_ctrl.sv
// Halt drain controller: on a halt seen in decode, stop fetch and count
// DEPTH unstalled cycles so the pipeline empties.  Then sit in DONE until
// reset.  A halt squashed by a mispredict before it has advanced
// (drain_cnt==0) cancels the drain.
module pipe_drain_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  pipe_drain_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(DEPTH - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       last_c;

  // Next-state, next-count and the combinational last strobe.
  always_comb begin
    // NOTE: every variable gets a default up front so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    last_c  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.halt_req && !bus.flush) begin
          state_d = ST_DRAIN;
          cnt_d   = 4'd0;
        end
      end
      ST_DRAIN: begin
        // A flush only squashes the halt while it is still in decode.
        if (cnt_q == 4'd0 && bus.flush) begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
        end else if (!bus.stall) begin
          if (cnt_q == LAST_CNT) begin
            last_c  = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and counter registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Fetch stops in the very cycle a valid (unsquashed) halt is decoded.
  assign bus.fetch_en  = (state_q == ST_RUN) && !(bus.halt_req && !bus.flush);
  assign bus.drain     = (state_q == ST_DRAIN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.last      = last_c;
  assign bus.drain_cnt = cnt_q;

endmodule

// File: doc/pipe_drain_ctrl.md
PIPE_DRAIN_CTRL -- requirements
Module: pipe_drain_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, SHALL be the number of unstalled cycles the pipeline needs to drain after a halt; legal range 1..15.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 halt_req  input  1  SHALL be high for each cycle a halt instruction is present in decode.
REQ-005 stall  input  1  SHALL be the pipeline hazard stall; high freezes drain progress.
REQ-006 flush  input  1  SHALL be the branch-mispredict squash of the decode stage.
REQ-007 fetch_en  output  1  SHALL enable instruction fetch / PC update.
REQ-008 drain  output  1  SHALL be high while the pipeline is draining.
REQ-009 last  output  1  SHALL pulse high on the final drain cycle, which retires the halt.
REQ-010 done  output  1  SHALL be high once the processor is fully halted.
REQ-011 drain_cnt  output  4  SHALL be the current drain count, for debug.

Function
REQ-012 The block SHALL implement three states: RUN, DRAIN and DONE.
REQ-013 RUN behaviour:
- halt_req=1 and flush=0: next state DRAIN, drain_cnt=0.
- halt_req=1 and flush=1: flush wins; state stays RUN.
REQ-014 fetch_en SHALL be combinational: fetch_en = (state==RUN) AND NOT (halt_req AND NOT flush).
- Fetch therefore stops in the same cycle a valid halt is seen.
- fetch_en SHALL be 0 in DRAIN and DONE.
REQ-015 In DRAIN with stall=1, drain_cnt SHALL hold its value.
REQ-016 In DRAIN with stall=0 and drain_cnt<DEPTH-1, drain_cnt SHALL increment by 1; it never wraps.
REQ-017 In DRAIN with stall=0 and drain_cnt==DEPTH-1:
- last=1 combinationally in that cycle;
- next state DONE; drain_cnt holds at DEPTH-1.
REQ-018 In DRAIN with drain_cnt==0 and flush=1 (halt squashed on the wrong path):
- next state RUN, drain_cnt=0, last=0;
- this has priority over stall and over REQ-017 (covers DEPTH=1).
REQ-019 flush in DRAIN with drain_cnt>0 SHALL be ignored, because the halt is already past the squash point.
REQ-020 halt_req SHALL be ignored in DRAIN and DONE.
REQ-021 Output decoding:
- drain = (state==DRAIN);
- done = (state==DONE), registered-state derived;
- last is asserted only from DRAIN.
REQ-022 DONE SHALL be absorbing: all inputs ignored, outputs fetch_en=0, drain=0, last=0, done=1, until rst.
REQ-023 At most one last pulse SHALL occur per halt.

Reset
REQ-024 rst=1 SHALL immediately (asynchronously) force:
- state RUN, drain_cnt=0;
- done=0, drain=0, last=0;
- fetch_en = 1 when halt_req=0.
REQ-025 Reset asserted mid-DRAIN or in DONE SHALL abandon the halt entirely; operation resumes in RUN on the first edge after deassertion.

Verification
REQ-026 Basic halt: DEPTH=4, halt_req pulse at cycle 0, stall=0 -> fetch_en=0 in cycle 0; drain=1 in cycles 1-4 with drain_cnt 0,1,2,3; last=1 in cycle 4; done=1 from cycle 5 on.
REQ-027 Stalled drain: DEPTH=4, stall=1 in cycles 2-3 -> drain_cnt holds at 1 during cycles 2-3; last occurs in cycle 6; done from cycle 7.
REQ-028 Squash: flush=1 in cycle 1 (drain_cnt=0) -> state RUN, fetch_en=1 in cycle 2; a later halt_req=1 with flush=0 halts normally. Same-cycle halt_req=1 with flush=1 in RUN -> no drain entered.
REQ-029 Late flush: flush=1 at drain_cnt=2 -> ignored; last and done timing identical to REQ-026.
REQ-030 DEPTH=1 boundaries:
- halt -> one DRAIN cycle with last=1, then done;
- flush in that DRAIN cycle -> RUN, last=0.
REQ-031 Async reset:
- rst pulsed between clock edges at drain_cnt=2 -> drain=0, drain_cnt=0, fetch_en=1 immediately;
- rst in DONE -> done=0.
